// File: rtl/output_writeback_buffer_if.sv
// Output-writeback bus: the result strobe from the conv controller and the drained output stream.
// Latency: none (wires only).
// Backpressure: only the drain side (out_valid/out_ready) carries any; the input side never stalls.
interface output_writeback_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [31:0]           in_x;
    logic [31:0]           in_y;
    logic [31:0]           in_ch;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output out_valid, out_data, out_addr, out_last
    );

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  out_valid, out_data, out_addr, out_last
    );
endinterface

// File: rtl/output_writeback_buffer.sv
// Captures conv outputs with (x,y,ch), converts them to a linear address and queues them in a FWFT FIFO.
// Latency: an entry pushed at edge N is on the output in cycle N+1 when the FIFO was empty.
// Backpressure: never stalls the input; drops on full (overflow) or bad coordinate/state (coord_error).
module output_writeback_buffer #(
    parameter int DATA_WIDTH         = 32,
    parameter int ADDR_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                               clk,
    input  logic                               rst_in,
    input  logic                               start,
    output_writeback_buffer_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level,
    output logic                               overflow,
    output logic                               coord_error,
    output logic                               done
);
    localparam int     PTR_W = $clog2(FIFO_DEPTH);
    localparam int     CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam longint TOTAL = longint'(FEATURE_MAP_WIDTH) * longint'(FEATURE_MAP_HEIGHT)
                               * longint'(OUTPUT_NB_CHANNELS);
    localparam int     TOT_W = $clog2(TOTAL + 1);
    localparam logic [TOT_W-1:0] LAST_IDX = TOT_W'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem_dat  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [TOT_W-1:0]      accepted_cnt, popped_cnt;
    logic                  coords_ok, fifo_full, push, pop, run_start, last_push;
    logic                  drop_full, drop_coord;
    logic [ADDR_WIDTH-1:0] push_addr;

    assign coords_ok = (bus.in_x  < 32'(FEATURE_MAP_WIDTH))  &&
                       (bus.in_y  < 32'(FEATURE_MAP_HEIGHT)) &&
                       (bus.in_ch < 32'(OUTPUT_NB_CHANNELS));
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = bus.out_valid && bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push       = (state == S_ACTIVE) && bus.in_valid && coords_ok && (!fifo_full || pop);
    assign drop_full  = (state == S_ACTIVE) && bus.in_valid && coords_ok && fifo_full && !pop;
    assign drop_coord = bus.in_valid && ((state != S_ACTIVE) || !coords_ok);
    assign run_start  = start && ((state == S_IDLE) || (state == S_DONE));
    assign last_push  = push && (accepted_cnt == LAST_IDX);

    // Address computed in 64 bits so large feature maps cannot wrap before truncation.
    assign push_addr = ADDR_WIDTH'(((64'(bus.in_y) * 64'(FEATURE_MAP_WIDTH)) + 64'(bus.in_x))
                                   * 64'(OUTPUT_NB_CHANNELS) + 64'(bus.in_ch));

    // State register.
    always_ff @(posedge clk) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic for the run sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start)                  state_nxt = S_ACTIVE;
            S_ACTIVE: if (last_push)              state_nxt = S_DRAIN;
            S_DRAIN:  if (pop && bus.out_last)    state_nxt = S_DONE;
            S_DONE:   if (start)                  state_nxt = S_ACTIVE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // Output decode; head entry is gated so an empty FIFO presents zeros.
    always_comb begin
        bus.out_valid = (count != '0);
        bus.out_data  = bus.out_valid ? mem_dat[rd_ptr]  : '0;
        bus.out_addr  = bus.out_valid ? mem_addr[rd_ptr] : '0;
        bus.out_last  = bus.out_valid && (popped_cnt == LAST_IDX);
        fill_level    = count;
        done          = (state == S_DONE);
    end

    // FIFO storage; contents need no reset since reads are gated by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dat[wr_ptr]  <= bus.in_data;
            mem_addr[wr_ptr] <= push_addr;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Run counters and sticky error flags, cleared when a new run is armed.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            accepted_cnt <= '0;
            popped_cnt   <= '0;
            overflow     <= 1'b0;
            coord_error  <= 1'b0;
        end else if (run_start) begin
            accepted_cnt <= '0;
            popped_cnt   <= '0;
            overflow     <= 1'b0;
            coord_error  <= 1'b0;
        end else begin
            if (push)       accepted_cnt <= accepted_cnt + 1'b1;
            if (pop)        popped_cnt   <= popped_cnt + 1'b1;
            if (drop_full)  overflow     <= 1'b1;
            if (drop_coord) coord_error  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_output_writeback_buffer.sv
// Bench for output_writeback_buffer: scoreboard of expected (data, addr) filled at drive time.
// Latency: checks one-cycle fall-through and done timing.
// Backpressure: exercises stall, overflow, concurrent push/pop at full, and reset mid-drain.
module tb_output_writeback_buffer;
    localparam int DW = 32, AW = 32, DEPTH = 4, W = 2, H = 2, C = 2, TOTAL = 8;

    logic       clk = 1'b0;
    logic       rst_in;
    logic       start;
    logic [2:0] fill_level;
    logic       overflow, coord_error, done;

    output_writeback_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    output_writeback_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH),
        .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .OUTPUT_NB_CHANNELS(C)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .bus(bus),
        .fill_level(fill_level), .overflow(overflow), .coord_error(coord_error), .done(done)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] exp_dat_q  [$];
    logic [AW-1:0] exp_addr_q [$];
    int pop_idx = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop side of the scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_in) begin
            exp_dat_q.delete();
            exp_addr_q.delete();
            pop_idx = 0;
        end else begin
            if (start) pop_idx = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_dat_q.size() == 0) begin
                    check_val("unexpected_pop", 64'(bus.out_addr), 64'hDEAD);
                end else begin
                    check_val("out_data", 64'(bus.out_data), 64'(exp_dat_q.pop_front()));
                    check_val("out_addr", 64'(bus.out_addr), 64'(exp_addr_q.pop_front()));
                    check_val("out_last", 64'(bus.out_last), 64'(pop_idx == TOTAL - 1));
                    pop_idx++;
                end
            end
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drive one strobe; returns at the negedge after the capturing edge.
    task automatic push(input int x, input int y, input int ch, input logic [DW-1:0] d,
                        input bit acc, input bit rdy);
        align();
        bus.out_ready = rdy;
        bus.in_valid  = 1'b1;
        bus.in_x      = 32'(x);
        bus.in_y      = 32'(y);
        bus.in_ch     = 32'(ch);
        bus.in_data   = d;
        if (acc) begin
            exp_dat_q.push_back(d);
            exp_addr_q.push_back(AW'((y * W + x) * C + ch));
        end
        align();
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_idx(input int i, input logic [DW-1:0] d, input bit acc, input bit rdy);
        push((i / C) % W, i / (W * C), i % C, d, acc, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        align();
        bus.out_ready = rdy;
        repeat (n - 1) align();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        align();
        start = 1'b1;
        align();
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        rst_in        = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b0;
        repeat (2) align();
        @(negedge clk);
        check_val("rst_out_valid", 64'(bus.out_valid), 0);
        check_val("rst_out_data",  64'(bus.out_data), 0);
        check_val("rst_out_addr",  64'(bus.out_addr), 0);
        check_val("rst_out_last",  64'(bus.out_last), 0);
        check_val("rst_fill",      64'(fill_level), 0);
        check_val("rst_overflow",  64'(overflow), 0);
        check_val("rst_coord_err", 64'(coord_error), 0);
        check_val("rst_done",      64'(done), 0);
        align();
        rst_in = 1'b0;

        // Run 1: streaming in raster order with the consumer always ready.
        pulse_start();
        for (int i = 0; i < TOTAL; i++) begin
            push_idx(i, 32'h100 + 32'(i), 1'b1, 1'b1);
            check_val("lat_valid", 64'(bus.out_valid), 1);
            check_val("lat_addr",  64'(bus.out_addr), 64'(i));
            check_val("lat_data",  64'(bus.out_data), 64'(32'h100 + i));
            if (i == TOTAL - 1) check_val("last_flag", 64'(bus.out_last), 1);
        end
        @(negedge clk);
        check_val("run1_done",     64'(done), 1);
        check_val("run1_overflow", 64'(overflow), 0);
        check_val("run1_fill",     64'(fill_level), 0);

        // Run 2: stall the consumer, fill up, overflow on the fifth push, then drain.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            push_idx(i, 32'h200 + 32'(i), i < 4, 1'b0);
            if (i == 3) check_val("ovf_fill4", 64'(fill_level), 4);
        end
        check_val("ovf_flag",      64'(overflow), 1);
        check_val("ovf_fill_hold", 64'(fill_level), 4);
        idle(6, 1'b1);
        check_val("ovf_drained", 64'(fill_level), 0);
        for (int i = 4; i < TOTAL; i++) push_idx(i, 32'h200 + 32'(i), 1'b1, 1'b1);
        wait_done(20);
        check_val("run2_ovf_sticky", 64'(overflow), 1);

        // Restart clears done and overflow.
        pulse_start();
        check_val("restart_done",     64'(done), 0);
        check_val("restart_overflow", 64'(overflow), 0);

        // Run 3: concurrent push/pop at full, then coordinate rejection.
        for (int i = 0; i < 4; i++) push_idx(i, 32'h300 + 32'(i), 1'b1, 1'b0);
        check_val("cc_fill_full", 64'(fill_level), 4);
        push_idx(4, 32'h304, 1'b1, 1'b1);
        check_val("cc_no_overflow", 64'(overflow), 0);
        check_val("cc_fill_hold",   64'(fill_level), 4);
        push(2, 0, 0, 32'hBAD, 1'b0, 1'b0);
        check_val("coord_err_flag",  64'(coord_error), 1);
        check_val("coord_err_fill",  64'(fill_level), 3);
        for (int i = 5; i < TOTAL; i++) push_idx(i, 32'h300 + 32'(i), 1'b1, 1'b1);
        wait_done(20);
        check_val("run3_overflow", 64'(overflow), 0);

        // Run 4: reset while draining with entries queued.
        pulse_start();
        for (int i = 0; i < 5; i++) push_idx(i, 32'h400 + 32'(i), 1'b1, 1'b1);
        idle(3, 1'b1);
        for (int i = 5; i < TOTAL; i++) push_idx(i, 32'h400 + 32'(i), 1'b1, 1'b0);
        check_val("mid_fill3", 64'(fill_level), 3);
        align();
        rst_in = 1'b1;
        align();
        rst_in = 1'b0;
        @(negedge clk);
        check_val("mrst_valid", 64'(bus.out_valid), 0);
        check_val("mrst_fill",  64'(fill_level), 0);
        check_val("mrst_done",  64'(done), 0);
        push(0, 0, 0, 32'h4FF, 1'b0, 1'b0);
        check_val("idle_coord_err", 64'(coord_error), 1);
        check_val("idle_fill",      64'(fill_level), 0);
        check_val("idle_valid",     64'(bus.out_valid), 0);
        align();
        check_val("sb_empty", 64'(exp_dat_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/output_writeback_buffer.md
Name: output_writeback_buffer

Overview:
- Sits directly downstream of the convolution loop controller/datapath. It captures each finished output pixel/channel value together with its (x, y, ch) coordinates on the controller's output-valid strobe.
- Converts the coordinates to a linear output-memory address and queues the result in a small FIFO.
- Drains the FIFO to the external output interface with a valid/ready handshake.
- The upstream controller cannot stall, so the block never backpressures its input; it detects and flags loss instead.

Parameters:
- DATA_WIDTH, 32, width of one output value.
- ADDR_WIDTH, 32, width of the linear output address.
- FIFO_DEPTH, 8, number of queued entries; power of two, at least 2.
- FEATURE_MAP_WIDTH, 1024, x range is 0..FEATURE_MAP_WIDTH-1.
- FEATURE_MAP_HEIGHT, 1024, y range is 0..FEATURE_MAP_HEIGHT-1.
- OUTPUT_NB_CHANNELS, 64, ch range is 0..OUTPUT_NB_CHANNELS-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_in  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new layer run.
- in_valid  in  1  output-valid strobe from the controller.
- in_data  in  DATA_WIDTH  output value.
- in_x  in  32  x coordinate.
- in_y  in  32  y coordinate.
- in_ch  in  32  output channel.
- out_valid  out  1  head FIFO entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  DATA_WIDTH  head entry value.
- out_addr  out  ADDR_WIDTH  head entry linear address.
- out_last  out  1  head entry is the final output of the run.
- fill_level  out  $clog2(FIFO_DEPTH+1)  current entry count.
- overflow  out  1  sticky: an input was dropped because the FIFO was full.
- coord_error  out  1  sticky: an input was dropped because a coordinate was out of range or it arrived outside ACTIVE.
- done  out  1  all outputs of the run have been handed off.

Behaviour:
- Reset (rst_in=1 at an edge): state IDLE, FIFO emptied. All outputs 0: out_valid, out_data, out_addr, out_last, fill_level, overflow, coord_error, done. Applies mid-run as well; queued data is discarded.
- TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS.
- accepted_cnt counts accepted pushes; popped_cnt counts pops.
- Address arithmetic: addr = ((in_y*FEATURE_MAP_WIDTH)+in_x)*OUTPUT_NB_CHANNELS + in_ch.
  - Computed at push time in full 64-bit precision, then truncated to ADDR_WIDTH.
- Push condition: state ACTIVE, in_valid=1, all coordinates in range, and (fill_level<FIFO_DEPTH or a pop occurs this same cycle).
  - Full with no simultaneous pop: the entry is dropped, overflow is set, fill_level is unchanged, accepted_cnt is unchanged.
  - Out-of-range coordinate, or in_valid in any state other than ACTIVE: the entry is dropped and coord_error is set.
- Pop condition: out_valid && out_ready.
- FIFO is first-word-fall-through with registered storage.
  - An entry pushed at edge N is visible on out_valid/out_data/out_addr in cycle N+1 (when the FIFO was empty).
  - While out_valid=1 and out_ready=0, out_data, out_addr and out_last stay stable.
- Simultaneous push and pop at any fill level: fill_level is unchanged and ordering is preserved.
- out_last = out_valid && (popped_cnt == TOTAL-1).
- State machine:
  - IDLE: start → ACTIVE.
  - ACTIVE: a push that makes accepted_cnt reach TOTAL → DRAIN.
  - DRAIN: the pop of the entry carrying out_last → DONE.
  - DONE: start → ACTIVE.
- Entering ACTIVE from IDLE or DONE clears accepted_cnt, popped_cnt, overflow, coord_error and done. The FIFO is already empty at that point.
- start in ACTIVE or DRAIN is ignored.
- done = 1 exactly while in DONE; it rises the cycle after the last pop.
- rst_in has priority over start and over every push/pop.

Test Plan:
Common parameters: W=2, H=2, C=2 (TOTAL=8), FIFO_DEPTH=4.
- Streaming: start, then 8 in_valid pulses in x,y,ch raster order with out_ready=1 → out_addr sequence 0,1,2,..,7 with matching data, one cycle latency each; out_last on the 8th; done=1 the next cycle; overflow=0.
- Backpressure overflow: out_ready=0, 5 pushes → fill_level=4 after the 4th; 5th dropped, overflow=1, fill_level stays 4. Then out_ready=1 drains entries 1–4 in order.
- Full with concurrent pop: fill_level=4, out_ready=1 and in_valid=1 in the same cycle → no overflow, fill_level stays 4, the new entry appears last.
- Coordinate check: push x=2,y=0,ch=0 → dropped, coord_error=1, fill_level and accepted_cnt unchanged. Push x=1,y=1,ch=1 → out_addr=7.
- Reset mid-drain: 3 entries queued in DRAIN, rst_in=1 for one cycle → next cycle out_valid=0, fill_level=0, done=0, state IDLE. Pushes now set coord_error only.
- Restart: in DONE with overflow=1, pulse start → done=0, overflow=0, and a new run of 8 reproduces the streaming result.
